// File: rtl/set_query_dispatcher.sv
// set_query_dispatcher
// Buffers SET circle-count queries in a small FIFO and issues them one at a
// time over SET's en/busy/valid handshake. Results (including rejected
// illegal-mode queries and watchdog aborts) are returned in query order
// through a single-entry result slot.
//
// state | meaning
// IDLE  | wait for a queued query, an empty result slot and SET not busy
// ISSUE | one-cycle set_en strobe; watchdog cleared
// WAIT  | SET counting; watchdog running until set_valid or timeout
// DRAIN | result captured; wait for SET to drop busy
module set_query_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        q_valid,
    output logic        q_ready,
    input  logic [23:0] q_central,
    input  logic [11:0] q_radius,
    input  logic [1:0]  q_mode,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [7:0]  r_candidate,
    output logic [1:0]  r_mode,
    output logic        r_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam int EW = 38;

    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full, empty;
    logic          push, pop, latch_set;
    logic [EW-1:0] head;
    logic [1:0]    head_mode;

    logic [CW-1:0] wdog_q, wdog_d;

    logic [23:0]   set_central_q;
    logic [11:0]   set_radius_q;
    logic [1:0]    set_mode_q;

    logic          r_valid_q, r_valid_d;
    logic [7:0]    r_candidate_q, r_candidate_d;
    logic [1:0]    r_mode_q, r_mode_d;
    logic          r_err_q, r_err_d;

    // FIFO status: pointers carry one extra wrap bit to tell full from empty.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign q_ready   = !full;
    assign push      = q_valid && !full;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign head_mode = head[1:0];

    assign wr_ptr_d  = wr_ptr_q + PW'(push);
    assign rd_ptr_d  = rd_ptr_q + PW'(pop);

    // Query storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {q_central, q_radius, q_mode};
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sequencer next state, pop decision, watchdog and result-slot updates.
    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        pop           = 1'b0;
        latch_set     = 1'b0;
        set_en        = 1'b0;
        r_valid_d     = r_valid_q;
        r_candidate_d = r_candidate_q;
        r_mode_d      = r_mode_q;
        r_err_d       = r_err_q;

        if (r_valid_q && r_ready) begin
            r_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Popping only into an empty slot keeps one query in flight,
                // so a result can never find the slot occupied.
                if (!empty && !r_valid_q && !set_busy) begin
                    pop = 1'b1;
                    if (head_mode == MODE_ILLEGAL) begin
                        r_valid_d     = 1'b1;
                        r_candidate_d = 8'h00;
                        r_mode_d      = head_mode;
                        r_err_d       = 1'b1;
                    end else begin
                        latch_set = 1'b1;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                set_en  = 1'b1;
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + CW'(1);
                if (set_valid) begin
                    r_valid_d     = 1'b1;
                    r_candidate_d = set_candidate;
                    r_mode_d      = set_mode_q;
                    r_err_d       = 1'b0;
                    state_d       = S_DRAIN;
                end else if (wdog_q == CW'(TIMEOUT - 1)) begin
                    // Engine hung: report an abort and let IDLE wait out busy.
                    r_valid_d     = 1'b1;
                    r_candidate_d = 8'hFF;
                    r_mode_d      = set_mode_q;
                    r_err_d       = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!set_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, watchdog and result slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wdog_q        <= '0;
            r_valid_q     <= 1'b0;
            r_candidate_q <= 8'h00;
            r_mode_q      <= 2'b00;
            r_err_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            r_valid_q     <= r_valid_d;
            r_candidate_q <= r_candidate_d;
            r_mode_q      <= r_mode_d;
            r_err_q       <= r_err_d;
        end
    end

    // Query fields presented to SET; held until the next legal pop because
    // SET re-reads mode on every busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_central_q <= 24'h000000;
            set_radius_q  <= 12'h000;
            set_mode_q    <= 2'b00;
        end else if (latch_set) begin
            set_central_q <= head[37:14];
            set_radius_q  <= head[13:2];
            set_mode_q    <= head[1:0];
        end
    end

    assign set_central = set_central_q;
    assign set_radius  = set_radius_q;
    assign set_mode    = set_mode_q;
    assign r_valid     = r_valid_q;
    assign r_candidate = r_candidate_q;
    assign r_mode      = r_mode_q;
    assign r_err       = r_err_q;

endmodule

// File: tb/tb_set_query_dispatcher.sv
// Bench for set_query_dispatcher: behavioural SET engine, result scoreboard,
// a table of single-query vectors and hand-written multi-cycle sequences.
module tb_set_query_dispatcher;

    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 100;
    localparam int HANG_LEN = 150;
    localparam int NV       = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        q_valid;
    logic        q_ready;
    logic [23:0] q_central;
    logic [11:0] q_radius;
    logic [1:0]  q_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        r_valid;
    logic        r_ready;
    logic [7:0]  r_candidate;
    logic [1:0]  r_mode;
    logic        r_err;

    always #5 clk = ~clk;

    set_query_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .q_valid(q_valid), .q_ready(q_ready),
        .q_central(q_central), .q_radius(q_radius), .q_mode(q_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate),
        .r_valid(r_valid), .r_ready(r_ready), .r_candidate(r_candidate),
        .r_mode(r_mode), .r_err(r_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference point count on the 8x8 grid (coordinates 1..8).
    function automatic logic [7:0] model_count(input logic [23:0] c, input logic [11:0] r,
                                               input logic [1:0] m);
        int x1, y1, x2, y2, r1, r2, n;
        x1 = int'(c[23:20]); y1 = int'(c[19:16]);
        x2 = int'(c[15:12]); y2 = int'(c[11:8]);
        r1 = int'(r[11:8]);  r2 = int'(r[7:4]);
        n = 0;
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                bit a, b;
                a = ((x - x1) * (x - x1) + (y - y1) * (y - y1)) <= r1 * r1;
                b = ((x - x2) * (x - x2) + (y - y2) * (y - y2)) <= r2 * r2;
                case (m)
                    2'b00: n += int'(a);
                    2'b01: n += int'(a && b);
                    2'b10: n += int'(a ^ b);
                    default: ;
                endcase
            end
        end
        return 8'(n);
    endfunction

    // Behavioural SET: samples en, counts 64 points, pulses valid, drops busy.
    logic hang_mode = 1'b0;
    logic job_hang;
    int   set_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_busy      <= 1'b0;
            set_valid     <= 1'b0;
            set_candidate <= 8'h00;
            set_cnt       <= 0;
            job_hang      <= 1'b0;
        end else if (!set_busy) begin
            set_valid <= 1'b0;
            if (set_en) begin
                set_busy <= 1'b1;
                set_cnt  <= 0;
                job_hang <= hang_mode;
            end
        end else if (job_hang) begin
            if (set_cnt == HANG_LEN) set_busy <= 1'b0;
            else set_cnt <= set_cnt + 1;
        end else if (set_cnt == 64) begin
            set_busy  <= 1'b0;
            set_valid <= 1'b0;
        end else begin
            set_cnt <= set_cnt + 1;
            if (set_cnt == 63) begin
                set_valid     <= 1'b1;
                set_candidate <= model_count(set_central, set_radius, set_mode);
            end
        end
    end

    typedef struct packed {
        logic [7:0] cand;
        logic [1:0] mode;
        logic       err;
    } res_t;

    res_t sb[$];
    int   push_q[$], en_q[$], rv_q[$], bf_q[$];
    int   cyc = 0;
    int   en_count = 0;
    int   rv_rise_count = 0;
    logic prev_en = 1'b0, prev_busy = 1'b0, prev_rv = 1'b0, prev_hs = 1'b0;
    logic [1:0]  prev_mode = 2'b00;
    logic [23:0] prev_c = 24'h0;
    logic [7:0]  prev_rc = 8'h00;
    logic [1:0]  prev_rm = 2'b00;
    logic        prev_re = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        res_t e;
        res_t g;
        if (rst_n) begin
            if (q_valid && q_ready) begin
                e.mode = q_mode;
                if (q_mode == 2'b11) begin
                    e.cand = 8'h00; e.err = 1'b1;
                end else if (hang_mode) begin
                    e.cand = 8'hFF; e.err = 1'b1;
                end else begin
                    e.cand = model_count(q_central, q_radius, q_mode); e.err = 1'b0;
                end
                sb.push_back(e);
                push_q.push_back(cyc);
            end
            if (set_en) begin
                en_count++;
                en_q.push_back(cyc);
                chk("en_while_busy", 32'(set_busy), 32'd0);
                chk("en_single_cycle", 32'(prev_en), 32'd0);
            end
            if (prev_busy && !set_busy) bf_q.push_back(cyc);
            if (set_busy && prev_busy) begin
                chk("set_mode_hold", 32'(set_mode), 32'(prev_mode));
                chk("set_central_hold", 32'(set_central), 32'(prev_c));
            end
            if (prev_rv && !prev_hs) begin
                chk("r_valid_hold", 32'(r_valid), 32'd1);
                chk("r_data_hold", {21'd0, r_candidate, r_mode, r_err}, {21'd0, prev_rc, prev_rm, prev_re});
            end
            if (r_valid && !prev_rv) begin
                rv_rise_count++;
                rv_q.push_back(cyc);
            end
            if (r_valid && r_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: actual cand=%0h err=%0b required none", r_candidate, r_err);
                end else begin
                    g = sb.pop_front();
                    chk("res_cand", 32'(r_candidate), 32'(g.cand));
                    chk("res_err", 32'(r_err), 32'(g.err));
                    chk("res_mode", 32'(r_mode), 32'(g.mode));
                end
            end
        end
        prev_en   = set_en;
        prev_busy = set_busy;
        prev_mode = set_mode;
        prev_c    = set_central;
        prev_rv   = r_valid;
        prev_hs   = r_valid && r_ready;
        prev_rc   = r_candidate;
        prev_rm   = r_mode;
        prev_re   = r_err;
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100000;
    endfunction

    task automatic clear_logs();
        push_q.delete(); en_q.delete(); rv_q.delete(); bf_q.delete();
    endtask

    task automatic drive_query(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        q_valid = 1'b1; q_central = c; q_radius = r; q_mode = m;
        @(posedge clk); #1;
        q_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_q_ready"}, 32'(q_ready), 32'd1);
        chk({tag, "_set_en"}, 32'(set_en), 32'd0);
        chk({tag, "_set_central"}, 32'(set_central), 32'd0);
        chk({tag, "_set_radius"}, 32'(set_radius), 32'd0);
        chk({tag, "_set_mode"}, 32'(set_mode), 32'd0);
        chk({tag, "_r_valid"}, 32'(r_valid), 32'd0);
        chk({tag, "_r_candidate"}, 32'(r_candidate), 32'd0);
        chk({tag, "_r_mode"}, 32'(r_mode), 32'd0);
        chk({tag, "_r_err"}, 32'(r_err), 32'd0);
    endtask

    typedef struct packed {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        logic [7:0]  exp_cand;
        logic        exp_err;
    } vec_t;

    vec_t vec [NV];

    initial begin
        int e0, r0, got, waited;
        logic [23:0] c;

        // {central, radius, mode, expected candidate, expected err}
        vec[0] = {24'h446600, 12'h330, 2'b00, 8'd29, 1'b0};
        vec[1] = {24'h446600, 12'h330, 2'b01, 8'd0, 1'b0};
        vec[2] = {24'h446600, 12'h330, 2'b10, 8'd0, 1'b0};
        vec[3] = {24'h118800, 12'h220, 2'b10, 8'd0, 1'b0};
        vec[4] = {24'h553300, 12'h210, 2'b11, 8'd0, 1'b1};
        vec[5] = {24'h881100, 12'h000, 2'b00, 8'd1, 1'b0};
        vec[6] = {24'h454500, 12'hFF0, 2'b00, 8'd64, 1'b0};
        vec[7] = {24'h454500, 12'hFF0, 2'b10, 8'd0, 1'b0};
        for (int i = 1; i <= 3; i++) vec[i].exp_cand = model_count(vec[i].c, vec[i].r, vec[i].m);

        q_valid = 1'b0; q_central = '0; q_radius = '0; q_mode = '0;
        r_ready = 1'b0; rst_n = 1'b0;
        #1;
        check_reset("reset_init");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single queries with latency checks.
        r_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            clear_logs();
            e0 = en_count;
            drive_query(vec[i].c, vec[i].r, vec[i].m);
            got = 0;
            for (int k = 0; k < 300 && got == 0; k++) begin
                @(negedge clk);
                if (r_valid) got = 1;
            end
            chk($sformatf("vec%0d_seen", i), 32'(got), 32'd1);
            if (got == 1) begin
                chk($sformatf("vec%0d_cand", i), 32'(r_candidate), 32'(vec[i].exp_cand));
                chk($sformatf("vec%0d_err", i), 32'(r_err), 32'(vec[i].exp_err));
            end
            wait_drain(50, $sformatf("vec%0d_drain", i));
            if (vec[i].m != 2'b11) begin
                chk($sformatf("vec%0d_en_pulses", i), 32'(en_count - e0), 32'd1);
                chk($sformatf("vec%0d_en_lat", i), 32'(qget(en_q, 0) - qget(push_q, 0)), 32'd2);
                chk($sformatf("vec%0d_rv_lat", i), 32'(qget(rv_q, 0) - qget(en_q, 0)), 32'd66);
            end else begin
                chk($sformatf("vec%0d_en_pulses", i), 32'(en_count - e0), 32'd0);
                chk($sformatf("vec%0d_rv_lat", i), 32'(qget(rv_q, 0) - qget(push_q, 0)), 32'd2);
            end
        end

        // Back-to-back mode 01 then 10: second issue right after busy drops.
        clear_logs();
        e0 = en_count;
        drive_query(24'h446600, 12'h330, 2'b01);
        drive_query(24'h446600, 12'h330, 2'b10);
        wait_drain(300, "b2b_drain");
        chk("b2b_en_pulses", 32'(en_count - e0), 32'd2);
        chk("b2b_second_issue", 32'(qget(en_q, 1) - qget(rv_q, 0)), 32'd2);
        chk("b2b_after_busy", 32'(qget(en_q, 1) - qget(bf_q, 0)), 32'd2);

        // Fill FIFO with result consumer stalled.
        clear_logs();
        e0 = en_count;
        r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = {4'(i + 1), 4'(i + 2), 4'(8 - i), 4'(7 - i), 8'h00};
            q_valid = 1'b1; q_central = c; q_radius = {4'(i + 2), 4'd3, 4'd0};
            q_mode = 2'(i % 3);
            @(negedge clk);
            chk($sformatf("fill%0d_q_ready", i), 32'(q_ready), 32'd1);
            @(posedge clk); #1;
        end
        q_valid = 1'b0;
        @(negedge clk);
        chk("full_q_ready", 32'(q_ready), 32'd0);
        repeat (150) @(posedge clk);
        @(negedge clk);
        chk("full_one_issued", 32'(en_count - e0), 32'd1);
        chk("full_slot_held", 32'(r_valid), 32'd1);
        chk("full_still_full", 32'(q_ready), 32'd0);
        q_valid = 1'b1; q_central = 24'h263700; q_radius = 12'h240; q_mode = 2'b10;
        r_ready = 1'b1;
        waited = 0;
        while (waited <= 200) begin
            @(negedge clk);
            if (q_ready) break;
            waited++;
        end
        chk("held_valid_accepted", 32'(waited <= 200), 32'd1);
        @(posedge clk); #1;
        q_valid = 1'b0;
        wait_drain(600, "full_drain");
        chk("full_en_pulses", 32'(en_count - e0), 32'd6);

        // Illegal mode between two legal queries.
        clear_logs();
        e0 = en_count;
        drive_query(24'h337500, 12'h430, 2'b00);
        drive_query(24'h337500, 12'h430, 2'b11);
        drive_query(24'h337500, 12'h430, 2'b01);
        wait_drain(300, "illegal_drain");
        chk("illegal_en_pulses", 32'(en_count - e0), 32'd2);
        chk("illegal_results", 32'(rv_q.size()), 32'd3);

        // Hung engine: watchdog abort, next issue waits for busy low.
        clear_logs();
        e0 = en_count;
        hang_mode = 1'b1;
        drive_query(24'h446600, 12'h330, 2'b01);
        waited = 0;
        while (rv_q.size() == 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        chk("hang_result_seen", 32'(rv_q.size()), 32'd1);
        #1;
        hang_mode = 1'b0;
        drive_query(24'h446600, 12'h330, 2'b00);
        wait_drain(400, "hang_drain");
        chk("hang_timeout_lat", 32'(qget(rv_q, 0) - qget(en_q, 0)), 32'(TIMEOUT + 1));
        chk("hang_en_pulses", 32'(en_count - e0), 32'd2);
        chk("hang_next_after_busy", 32'(qget(en_q, 1) - qget(bf_q, 0)), 32'd1);

        // Reset in the middle of WAIT with three queries queued.
        clear_logs();
        r_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_query({4'(i + 2), 4'd4, 4'd5, 4'd5, 8'h00}, 12'h320, 2'b00);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset("reset_mid");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        e0 = en_count;
        r0 = rv_rise_count;
        repeat (200) @(posedge clk);
        #1;
        chk("post_reset_no_issue", 32'(en_count - e0), 32'd0);
        chk("post_reset_no_result", 32'(rv_rise_count - r0), 32'd0);
        chk("post_reset_r_valid", 32'(r_valid), 32'd0);
        chk("post_reset_q_ready", 32'(q_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/set_query_dispatcher.md
# set_query_dispatcher

Upstream feeder for the SET circle-counting engine. Accepts set queries (two circle centres, two radii, mode) over a valid/ready stream, buffers them in a small FIFO, and issues them one at a time to SET over its `en`/`busy`/`valid` protocol. It returns each candidate count, in query order, on a result valid/ready stream. It also rejects illegal modes and guards against a hung engine with a watchdog.

## Interface
- `DEPTH`, 4: query FIFO entries; power of two, at least 2.
- `TIMEOUT`, 100: maximum cycles in WAIT before an aborted result is forced; must be greater than 66.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `q_valid` in 1: query present.
- `q_ready` out 1: FIFO can accept a query.
- `q_central` in 24: {x1,y1,x2,y2,8'h00}, 4 bits each.
- `q_radius` in 12: {r1,r2,4'h0}.
- `q_mode` in 2: 00 = in A, 01 = in A∩B, 10 = in A xor B, 11 = illegal.
- `set_en` out 1: one-cycle issue strobe to SET.
- `set_central` out 24, `set_radius` out 12, `set_mode` out 2: registered query fields; held stable from issue until the end of DRAIN.
- `set_busy` in 1, `set_valid` in 1, `set_candidate` in 8: status and result from SET.
- `r_valid` out 1: result slot full.
- `r_ready` in 1: result consumer accepts.
- `r_candidate` out 8: point count.
- `r_mode` out 2: mode of the query.
- `r_err` out 1: 1 = illegal mode or timeout.

## Operation
- FIFO: push on `q_valid && q_ready`. `q_ready = !full`. There is no fall-through; a push and a pop in the same cycle are both honoured. Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- Result slot: single register. Cleared on `r_valid && r_ready`. A new query is popped only when the slot is empty, so at most one query is in flight and a result never finds the slot full.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE, when the FIFO is non-empty, the slot is empty and `set_busy` = 0:
  - Pop the head entry.
  - If its mode = 11: load the slot directly with candidate 0, `r_err` = 1, that mode; stay in IDLE.
  - Otherwise: latch the fields into the `set_*` registers and go to ISSUE.
- ISSUE: `set_en` = 1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: increment the watchdog counter each cycle.
  - If `set_valid` = 1: load the slot with `set_candidate`, `r_err` = 0, `set_mode`; go to DRAIN.
  - Otherwise, if the counter reaches TIMEOUT-1: load the slot with candidate 8'hFF, `r_err` = 1; go to IDLE. IDLE still waits for `set_busy` low before the next issue.
- DRAIN: go to IDLE when `set_busy` = 0. The `set_*` fields are held throughout, because SET reads mode every busy cycle.
- `set_valid` outside WAIT is ignored.
- Results leave in the same order as queries were accepted, including illegal-mode results.
- Candidate width: 8 bits, maximum legal count 64. No saturation is needed.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE; FIFO empty; slot empty; watchdog counter 0.
  - `q_ready` = 1 (combinational from !full, full = 0 in reset).
  - `set_en` = 0, `set_central` = 0, `set_radius` = 0, `set_mode` = 0.
  - `r_valid` = 0, `r_candidate` = 0, `r_mode` = 0, `r_err` = 0.
- Reset mid-query discards the FIFO, the slot and the in-flight query. SET is reset by the same top-level reset.
- Query latency, counted in rising edges from the push edge P:
  - P+1: `set_en` high.
  - P+2: edge at which SET samples `en`.
  - P+2 to P+66: SET counts its 64 grid points and raises `set_valid` (SET's own schedule).
  - P+67: capture edge; `r_valid` high after it, in the same cycle SET drops `busy`.
  - P+68: DRAIN ends.
  - P+69: edge at which the next query is popped; its `set_en` is high in the cycle after it.
- Illegal mode: `r_valid` is high one edge after the pop.
- `r_valid` and its data stay stable until accepted. `r_ready` may be held high; the slot accepts again the cycle after it empties.
- Full FIFO: `q_ready` = 0; a `q_valid` held high is accepted on the first cycle after a pop.

## Test plan
- Single query, central=24'h446600, radius=12'h330, mode 00 → exactly one `set_en` pulse; `r_valid` 66 edges after `set_en`; `r_candidate` = 29, `r_err` = 0.
- Same centres, mode 01, then mode 10, pushed back-to-back → two results in order; the second `set_en` pulse is no earlier than the edge after SET drops `busy`; `set_mode` is stable across each busy window.
- DEPTH+1 = 5 queries pushed on consecutive cycles while `r_ready` = 0 → `q_ready` low exactly when 4 are queued; only one issued; the slot holds result 1 until `r_ready` = 1, then the remaining four drain in order.
- Mode 11 query between two legal ones → no `set_en` for it; its result is `r_candidate` = 0, `r_err` = 1, in order between the legal results.
- SET model that never asserts `set_valid` → result `r_candidate` = 8'hFF, `r_err` = 1 after TIMEOUT cycles in WAIT; the next query is issued only after `set_busy` = 0.
- `rst_n` pulled low in the middle of WAIT with 3 queries queued → all outputs at reset values immediately; no stale result after release.
